// File: rtl/lstm_pkg.sv
// Shared constants and state encoding for the LSTM gate datapath and its sequencer.
package lstm_pkg;

    localparam int TILE_W       = 6;
    localparam int DEF_PIPE_LAT = 5;
    localparam int DEF_ACC_LAT  = 1;

    typedef logic [TILE_W-1:0] tile_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_X,
        S_ISSUE_H,
        S_DRAIN,
        S_BIAS,
        S_WAIT,
        S_DONE
    } gc_state_e;

endpackage

// File: rtl/gate_ctrl_if.sv
// Control bundle between a gate sequencer and its requester / datapath.
interface gate_ctrl_if;
    import lstm_pkg::*;

    logic  start;
    tile_t nx_tiles;
    tile_t nh_tiles;
    logic  busy;
    logic  done;
    tile_t tile_idx;
    logic  mux_mult_sel;
    logic  mux_acc_sel;
    logic  accum_rst;

    modport master (
        output start, nx_tiles, nh_tiles,
        input  busy, done, tile_idx,
        input  mux_mult_sel, mux_acc_sel, accum_rst
    );

    modport slave (
        input  start, nx_tiles, nh_tiles,
        output busy, done, tile_idx,
        output mux_mult_sel, mux_acc_sel, accum_rst
    );

endinterface

// File: rtl/gate_ctrl.sv
// Tile sequencer for one gate: issues x/h tiles, clears and biases the
// accumulator in step with the datapath pipeline, then pulses done.
module gate_ctrl
    import lstm_pkg::*;
#(
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int ACC_LAT  = DEF_ACC_LAT
) (
    input  logic        clk,
    input  logic        rst,
    gate_ctrl_if.slave  bus
);

    localparam int DLY_W = $clog2(PIPE_LAT + 1);

    localparam tile_t PIPE_M1 = tile_t'(PIPE_LAT - 1);
    localparam tile_t WAIT_M1 = tile_t'((ACC_LAT > 1) ? ACC_LAT - 2 : 0);
    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(PIPE_LAT);

    gc_state_e        state_q, state_d;
    tile_t            cnt_q, cnt_d;
    tile_t            nx_q, nx_d;
    tile_t            nh_q, nh_d;
    logic [DLY_W-1:0] dly_q, dly_d;

    logic  busy_q, busy_d;
    logic  done_q, done_d;
    tile_t tile_idx_q, tile_idx_d;
    logic  mult_sel_q, mult_sel_d;
    logic  acc_sel_q, acc_sel_d;
    logic  acc_rst_q, acc_rst_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nx_d    = nx_q;
        nh_d    = nh_q;
        // Counts down from start so the first product sum meets a cleared accumulator.
        dly_d   = (dly_q != '0) ? dly_q - 1'b1 : dly_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    nx_d  = bus.nx_tiles;
                    nh_d  = bus.nh_tiles;
                    dly_d = DLY_INIT;
                    if (bus.nx_tiles != '0) begin
                        state_d = S_ISSUE_X;
                        cnt_d   = '0;
                    end else if (bus.nh_tiles != '0) begin
                        state_d = S_ISSUE_H;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_DRAIN;
                        cnt_d   = PIPE_M1;
                    end
                end
            end
            S_ISSUE_X: begin
                if (cnt_q == nx_q - 1'b1) begin
                    if (nh_q != '0) begin
                        state_d = S_ISSUE_H;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_DRAIN;
                        cnt_d   = PIPE_M1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ISSUE_H: begin
                if (cnt_q == nh_q - 1'b1) begin
                    state_d = S_DRAIN;
                    cnt_d   = PIPE_M1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_BIAS;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_BIAS: begin
                if (ACC_LAT > 1) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_M1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        mult_sel_d = (state_d == S_ISSUE_H);
        acc_sel_d  = (state_d == S_BIAS);
        acc_rst_d  = (state_d == S_IDLE) || (dly_d != '0);
        tile_idx_d = '0;
        if (state_d == S_ISSUE_X || state_d == S_ISSUE_H) begin
            tile_idx_d = cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            nx_q       <= '0;
            nh_q       <= '0;
            dly_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tile_idx_q <= '0;
            mult_sel_q <= 1'b0;
            acc_sel_q  <= 1'b0;
            acc_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nx_q       <= nx_d;
            nh_q       <= nh_d;
            dly_q      <= dly_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tile_idx_q <= tile_idx_d;
            mult_sel_q <= mult_sel_d;
            acc_sel_q  <= acc_sel_d;
            acc_rst_q  <= acc_rst_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.tile_idx     = tile_idx_q;
    assign bus.mux_mult_sel = mult_sel_q;
    assign bus.mux_acc_sel  = acc_sel_q;
    assign bus.accum_rst    = acc_rst_q;

endmodule

// File: tb/tb_gate_ctrl.sv
// Bench for gate_ctrl: directed scenarios plus random traffic against a
// cycle-offset model of the sequencer timing.
module tb_gate_ctrl;
    import lstm_pkg::*;

    localparam int PL = DEF_PIPE_LAT;
    localparam int AL = DEF_ACC_LAT;
    localparam int VW = 5 + TILE_W;

    logic clk;
    logic rst;

    gate_ctrl_if bus();

    gate_ctrl #(.PIPE_LAT(PL), .ACC_LAT(AL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int cyc;
    int s;
    int mnx;
    int mnh;
    bit have;
    logic [VW-1:0] exp_v;
    logic [VW-1:0] obs_v;

    function automatic int txn_len();
        return PL + 1 + mnx + mnh + AL;
    endfunction

    function automatic bit model_busy(input int t);
        return have && (t - s) >= 1 && (t - s) <= txn_len();
    endfunction

    // Expected outputs for cycle t, from cycle offsets relative to start.
    function automatic logic [VW-1:0] model_out(input int t);
        int k;
        int n;
        logic b, dn, ms, ma, ar;
        logic [TILE_W-1:0] ti;
        b = 0; dn = 0; ms = 0; ma = 0; ar = 1; ti = '0;
        if (model_busy(t)) begin
            n  = mnx + mnh;
            k  = t - s;
            b  = 1'b1;
            dn = (k == txn_len());
            ma = (k == PL + 1 + n);
            ar = (k <= PL);
            if (k <= n) begin
                ms = (k > mnx);
                ti = ms ? TILE_W'(k - mnx - 1) : TILE_W'(k - 1);
            end
        end
        return {b, dn, ms, ma, ar, ti};
    endfunction

    task automatic tick(input logic st, input int nx, input int nh,
                        input logic r);
        bus.start    = st;
        bus.nx_tiles = TILE_W'(nx);
        bus.nh_tiles = TILE_W'(nh);
        rst          = r;
        if (r) begin
            have = 0;
        end else if (st && !model_busy(cyc)) begin
            have = 1;
            s    = cyc;
            mnx  = nx;
            mnh  = nh;
        end
        @(posedge clk);
        #1;
        cyc++;
        exp_v = model_out(cyc);
        obs_v = {bus.busy, bus.done, bus.mux_mult_sel, bus.mux_acc_sel,
                 bus.accum_rst, bus.tile_idx};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 0, 0, 1'b1);
            checks++;
            if (obs_v !== {5'b00001, {TILE_W{1'b0}}}) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs_v,
                         {5'b00001, {TILE_W{1'b0}}});
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 0, 0, 1'b0);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_basic();
        int s0;
        int dc;
        int fc;
        s0 = cyc; dc = -1; fc = -1;
        for (int i = 0; i < 14; i++) begin
            tick(i == 0, 2, 1, 1'b0);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (bus.done && dc < 0) dc = cyc - s0;
            if (!bus.accum_rst && fc < 0) fc = cyc - s0;
        end
        checks++;
        if (dc !== 10) begin
            failures++;
            $display("FAIL basic_done_off got=%0d exp=10", dc);
        end
        checks++;
        if (fc !== 6) begin
            failures++;
            $display("FAIL basic_accrst_off got=%0d exp=6", fc);
        end
    endtask

    task automatic test_zero();
        int s0;
        int dc;
        int bc;
        s0 = cyc; dc = -1; bc = -1;
        for (int i = 0; i < 10; i++) begin
            tick(i == 0, 0, 0, 1'b0);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL zero cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (bus.done && dc < 0) dc = cyc - s0;
            if (bus.mux_acc_sel && bc < 0) bc = cyc - s0;
        end
        checks++;
        if (dc !== 7 || bc !== 6) begin
            failures++;
            $display("FAIL zero_offs got=%0d/%0d exp=7/6", dc, bc);
        end
    endtask

    task automatic test_h_only();
        int s0;
        int dc;
        s0 = cyc; dc = -1;
        for (int i = 0; i < 13; i++) begin
            tick(i == 0, 0, 3, 1'b0);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL h_only cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (bus.done && dc < 0) dc = cyc - s0;
        end
        checks++;
        if (dc !== 10) begin
            failures++;
            $display("FAIL h_only_done_off got=%0d exp=10", dc);
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        int nd;
        int d2;
        logic st;
        s0 = cyc; nd = 0; d2 = -1;
        for (int i = 0; i < 26; i++) begin
            st = (i == 0) || (i == 4) || (i == 10) || (i == 11);
            tick(st, (i == 4) ? 5 : 2, 1, 1'b0);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (bus.done) begin
                nd++;
                d2 = cyc - s0;
            end
        end
        checks++;
        if (nd !== 2 || d2 !== 21) begin
            failures++;
            $display("FAIL b2b_dones got=%0d@%0d exp=2@21", nd, d2);
        end
    endtask

    task automatic test_mid_reset();
        int s0;
        int nd;
        int d1;
        s0 = cyc; nd = 0; d1 = -1;
        for (int i = 0; i < 24; i++) begin
            tick((i == 0) || (i == 10), 2, 1, i == 7);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL mid_rst cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (cyc - s0 == 8) begin
                checks++;
                if (obs_v !== {5'b00001, {TILE_W{1'b0}}}) begin
                    failures++;
                    $display("FAIL mid_rst_vals got=%h exp=%h", obs_v,
                             {5'b00001, {TILE_W{1'b0}}});
                end
            end
            if (bus.done) begin
                nd++;
                d1 = cyc - s0;
            end
        end
        checks++;
        if (nd !== 1 || d1 !== 20) begin
            failures++;
            $display("FAIL mid_rst_dones got=%0d@%0d exp=1@20", nd, d1);
        end
    endtask

    task automatic test_random();
        logic st;
        logic r;
        int nx;
        int nh;
        for (int i = 0; i < 4000; i++) begin
            st = ($urandom_range(0, 5) == 0);
            r  = ($urandom_range(0, 299) == 0);
            nx = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63)
                                             : $urandom_range(0, 4);
            nh = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63)
                                             : $urandom_range(0, 4);
            tick(st, nx, nh, r);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        s        = 0;
        mnx      = 0;
        mnh      = 0;
        have     = 0;
        rst      = 1'b1;
        bus.start    = 1'b0;
        bus.nx_tiles = '0;
        bus.nh_tiles = '0;
        test_reset();
        test_basic();
        test_zero();
        test_h_only();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
